// File: rtl/spi_eater_fifo.sv
// spi_eater_fifo: command FIFO -> byte-wide SPI engine -> result FIFO.
// The host queues 9-bit words: control words update ctl_bits, data words
// are shifted out MSB first while miso is shifted in, and each received
// byte lands in the result FIFO. Bit timing comes from rising edges of pace.

// Show-ahead FIFO: dout is the oldest entry with no read latency.
module short_fifo #(
   parameter int aw = 4,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [dw-1:0] din,
   input  logic          we,
   input  logic          re,
   output logic [dw-1:0] dout,
   output logic [aw:0]   count
);
   logic [dw-1:0] mem [0:(1<<aw)-1];
   logic [aw-1:0] wptr, rptr;
   logic          full, empty, wr, rd;

   // count==depth is exactly the state with the top count bit set
   assign full  = count[aw];
   assign empty = (count == '0);
   // a full FIFO refuses writes even when a read frees a slot this cycle
   assign wr    = we & ~full;
   assign rd    = re & ~empty;
   assign dout  = mem[rptr];

   // storage; contents survive reset, only the pointers are cleared
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= din;
   end

   // pointers wrap naturally at depth; count tracks occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + aw'(1);
         if (rd) rptr <= rptr + aw'(1);
         case ({wr, rd})
            2'b10:   count <= count + (aw+1)'(1);
            2'b01:   count <= count - (aw+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module spi_eater_fifo #(
   parameter int infifo_aw  = 5,
   parameter int outfifo_aw = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [8:0]          host_din,
   input  logic                host_we,
   input  logic                pace,
   input  logic                miso,
   input  logic                result_re,
   output logic                sclk,
   output logic                mosi,
   output logic [5:0]          ctl_bits,
   output logic [7:0]          result_dout,
   output logic                cmd_full,
   output logic                cmd_empty,
   output logic [outfifo_aw:0] result_count
);
   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nx;
   logic [8:0]       cmd_dout;
   logic [infifo_aw:0] cmd_count;
   logic             cmd_re;
   logic             pace_d1, pace_step;
   logic [4:0]       step_cnt;
   logic [7:0]       tx_sr, rx_sr;
   logic             result_we;

   short_fifo #(.aw(infifo_aw), .dw(9)) u_cmd (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (host_din),
      .we    (host_we),
      .re    (cmd_re),
      .dout  (cmd_dout),
      .count (cmd_count)
   );

   short_fifo #(.aw(outfifo_aw), .dw(8)) u_res (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (rx_sr),
      .we    (result_we),
      .re    (result_re),
      .dout  (result_dout),
      .count (result_count)
   );

   assign cmd_empty = (cmd_count == '0);
   assign cmd_full  = cmd_count[infifo_aw];
   assign pace_step = pace & ~pace_d1;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and command pull: idle pops one word per cycle
   always_comb begin
      state_nx = state;
      cmd_re   = 1'b0;
      case (state)
         IDLE: begin
            if (!cmd_empty) begin
               cmd_re = 1'b1;
               if (!cmd_dout[8]) state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (pace_step && step_cnt == 5'd16) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // datapath: even steps drive mosi, odd steps raise sclk and sample miso,
   // step 16 drops sclk and posts the received byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pace_d1   <= 1'b0;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         ctl_bits  <= '0;
         result_we <= 1'b0;
         step_cnt  <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
      end else begin
         pace_d1   <= pace;
         result_we <= 1'b0;
         if (state == IDLE) begin
            sclk <= 1'b0;
            if (cmd_re) begin
               if (cmd_dout[8]) begin
                  ctl_bits <= cmd_dout[5:0];
               end else begin
                  tx_sr    <= cmd_dout[7:0];
                  step_cnt <= '0;
               end
            end
         end else if (pace_step) begin
            if (step_cnt == 5'd16) begin
               sclk      <= 1'b0;
               result_we <= 1'b1;
               step_cnt  <= '0;
            end else begin
               if (!step_cnt[0]) begin
                  sclk  <= 1'b0;
                  mosi  <= tx_sr[7];
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end else begin
                  sclk  <= 1'b1;
                  rx_sr <= {rx_sr[6:0], miso};
               end
               step_cnt <= step_cnt + 5'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_eater_fifo.sv
// Bench for spi_eater_fifo: scoreboard queues for results and ctl_bits
// updates, monitors for sclk pulses and mosi at sclk rising edges.
module tb_spi_eater_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] host_din = '0;
   logic       host_we = 1'b0;
   logic       pace = 1'b0;
   logic       miso;
   logic       result_re = 1'b0;
   logic       sclk, mosi;
   logic [5:0] ctl_bits;
   logic [7:0] result_dout;
   logic       cmd_full, cmd_empty;
   logic [4:0] result_count;

   logic       loop_en = 1'b0;
   logic       miso_val = 1'b0;
   logic       pace_en = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [5:0] ctl_q[$];

   int         pulses = 0;
   logic [7:0] cap = '0;
   logic       sclk_prev = 1'b0;
   int         ctl_changes = 0;
   logic [5:0] ctl_prev = '0;

   assign miso = loop_en ? mosi : miso_val;

   spi_eater_fifo #(.infifo_aw(5), .outfifo_aw(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_din     (host_din),
      .host_we      (host_we),
      .pace         (pace),
      .miso         (miso),
      .result_re    (result_re),
      .sclk         (sclk),
      .mosi         (mosi),
      .ctl_bits     (ctl_bits),
      .result_dout  (result_dout),
      .cmd_full     (cmd_full),
      .cmd_empty    (cmd_empty),
      .result_count (result_count)
   );

   always #5 clk = ~clk;

   // pace: toggles every 2 clocks when enabled, so one step per 4 clocks
   initial begin
      int pc;
      pc = 0;
      forever begin
         @(negedge clk);
         if (!pace_en) begin
            pace = 1'b0;
            pc = 0;
         end else begin
            pc++;
            if (pc == 2) begin
               pace = ~pace;
               pc = 0;
            end
         end
      end
   end

   // sclk pulse counter and mosi capture at each sclk rise
   initial begin
      forever begin
         @(negedge clk);
         if (sclk === 1'b1 && sclk_prev !== 1'b1) begin
            pulses++;
            cap = {cap[6:0], mosi};
         end
         sclk_prev = sclk;
      end
   end

   // ctl_bits scoreboard: every change outside reset must match the queue head
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && ctl_bits !== ctl_prev) begin
            ctl_changes++;
            checks++;
            if (ctl_q.size() == 0) begin
               failures++;
               $display("FAIL ctl_unexpected got=%h expected=no change", ctl_bits);
            end else begin
               logic [5:0] e;
               e = ctl_q.pop_front();
               if (ctl_bits !== e) begin
                  failures++;
                  $display("FAIL ctl_order got=%h expected=%h", ctl_bits, e);
               end
            end
         end
         ctl_prev = ctl_bits;
      end
   end

   task automatic write_word(input logic [8:0] w);
      host_din = w;
      host_we  = 1'b1;
      @(negedge clk);
      host_we  = 1'b0;
   endtask

   task automatic wait_results(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (result_count < 5'(n) && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (result_count < 5'(n)) begin
         failures++;
         $display("FAIL %s_timeout result_count=%0d expected=%0d", name, result_count, n);
      end
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while (result_count != 0 && g < 40) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_extra got=%h expected=none", name, result_dout);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (result_dout !== e) begin
               failures++;
               $display("FAIL %s_data got=%h expected=%h", name, result_dout, e);
            end
         end
         result_re = 1'b1;
         @(negedge clk);
         result_re = 1'b0;
         g++;
      end
      checks++;
      if (exp_q.size() != 0 || result_count !== 5'd0) begin
         failures++;
         $display("FAIL %s_drain left=%0d result_count=%0d expected 0/0", name, exp_q.size(), result_count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (sclk !== 1'b0 || mosi !== 1'b0 || ctl_bits !== 6'h00) begin
         failures++;
         $display("FAIL reset_out sclk=%b mosi=%b ctl=%h expected 0/0/00", sclk, mosi, ctl_bits);
      end
      checks++;
      if (cmd_empty !== 1'b1 || cmd_full !== 1'b0 || result_count !== 5'd0) begin
         failures++;
         $display("FAIL reset_flags empty=%b full=%b rc=%0d expected 1/0/0", cmd_empty, cmd_full, result_count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ctl();
      int p0;
      pace_en = 1'b0;
      p0 = pulses;
      ctl_q.push_back(6'h05);
      write_word(9'h105);
      repeat (2) @(negedge clk);
      checks++;
      if (ctl_bits !== 6'h05) begin
         failures++;
         $display("FAIL ctl_value got=%h expected=05", ctl_bits);
      end
      checks++;
      if (cmd_empty !== 1'b1 || sclk !== 1'b0 || pulses != p0 || result_count !== 5'd0) begin
         failures++;
         $display("FAIL ctl_side empty=%b sclk=%b pulses=%0d rc=%0d expected 1/0/0/0", cmd_empty, sclk, pulses - p0, result_count);
      end
   endtask

   task automatic test_data_ones();
      int p0;
      loop_en = 1'b0;
      miso_val = 1'b1;
      pace_en = 1'b1;
      p0 = pulses;
      exp_q.push_back(8'hFF);
      write_word(9'h0A5);
      wait_results(1, 300, "ones");
      checks++;
      if (pulses - p0 != 8) begin
         failures++;
         $display("FAIL ones_pulses got=%0d expected=8", pulses - p0);
      end
      checks++;
      if (cap !== 8'hA5) begin
         failures++;
         $display("FAIL ones_mosi got=%h expected=a5", cap);
      end
      checks++;
      if (result_count !== 5'd1 || sclk !== 1'b0) begin
         failures++;
         $display("FAIL ones_count rc=%0d sclk=%b expected 1/0", result_count, sclk);
      end
      drain("ones");
   endtask

   task automatic test_loopback();
      loop_en = 1'b1;
      pace_en = 1'b1;
      exp_q.push_back(8'h3C);
      write_word(9'h03C);
      wait_results(1, 300, "loop");
      checks++;
      if (mosi !== 1'b0) begin
         failures++;
         $display("FAIL loop_mosi_hold got=%b expected=0", mosi);
      end
      drain("loop");
   endtask

   task automatic test_cmd_full();
      int c0, k;
      loop_en = 1'b1;
      pace_en = 1'b0;
      exp_q.push_back(8'h55);
      write_word(9'h055);
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_empty !== 1'b1) begin
         failures++;
         $display("FAIL full_engaged empty=%b expected=1", cmd_empty);
      end
      c0 = ctl_changes;
      for (int i = 0; i < 33; i++) begin
         logic [8:0] w;
         w = (i < 32) ? (9'h120 + 9'(i)) : 9'h101;
         if (i < 32) ctl_q.push_back(w[5:0]);
         host_din = w;
         host_we  = 1'b1;
         @(negedge clk);
         if (i == 30) begin
            checks++;
            if (cmd_full !== 1'b0) begin
               failures++;
               $display("FAIL full_early after31 full=%b expected=0", cmd_full);
            end
         end
         if (i == 31) begin
            checks++;
            if (cmd_full !== 1'b1) begin
               failures++;
               $display("FAIL full_flag after32 full=%b expected=1", cmd_full);
            end
         end
      end
      host_we = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_full !== 1'b1 || ctl_changes != c0) begin
         failures++;
         $display("FAIL full_hold full=%b ctl_changes=%0d expected 1/0", cmd_full, ctl_changes - c0);
      end
      pace_en = 1'b1;
      k = 0;
      while (!(cmd_empty === 1'b1 && result_count == 5'd1) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (ctl_changes - c0 != 32 || ctl_q.size() != 0 || ctl_bits !== 6'h3F) begin
         failures++;
         $display("FAIL full_exec changes=%0d left=%0d ctl=%h expected 32/0/3f", ctl_changes - c0, ctl_q.size(), ctl_bits);
      end
      drain("full");
   endtask

   task automatic test_result_full();
      int k;
      loop_en = 1'b1;
      pace_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         logic [7:0] v;
         v = 8'(i * 29 + 3);
         if (i < 16) exp_q.push_back(v);
         host_din = {1'b0, v};
         host_we  = 1'b1;
         @(negedge clk);
      end
      host_we = 1'b0;
      k = 0;
      while (cmd_empty !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      repeat (100) @(negedge clk);
      checks++;
      if (result_count !== 5'd16 || cmd_empty !== 1'b1) begin
         failures++;
         $display("FAIL rfull_count rc=%0d empty=%b expected 16/1", result_count, cmd_empty);
      end
      drain("rfull");
   endtask

   task automatic test_reset_mid();
      int p0, k;
      loop_en = 1'b1;
      pace_en = 1'b1;
      p0 = pulses;
      write_word(9'h0C3);
      write_word(9'h111);
      k = 0;
      while (pulses - p0 < 4 && k < 500) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (sclk !== 1'b1) begin
         failures++;
         $display("FAIL mid_reach sclk=%b pulses=%0d expected 1/4", sclk, pulses - p0);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (sclk !== 1'b0 || cmd_empty !== 1'b1 || result_count !== 5'd0 || ctl_bits !== 6'h00) begin
         failures++;
         $display("FAIL mid_reset sclk=%b empty=%b rc=%0d ctl=%h expected 0/1/0/00", sclk, cmd_empty, result_count, ctl_bits);
      end
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      checks++;
      if (result_count !== 5'd0 || sclk !== 1'b0 || pulses - p0 != 4) begin
         failures++;
         $display("FAIL mid_after rc=%0d sclk=%b pulses=%0d expected 0/0/4", result_count, sclk, pulses - p0);
      end
   endtask

   initial begin
      test_reset();
      test_ctl();
      test_data_ones();
      test_loopback();
      test_cmd_full();
      test_result_full();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_eater_fifo.md
SPI_EATER_FIFO -- requirements
Module: spi_eater_fifo

Interface
REQ-001 Parameter infifo_aw, default 5, SHALL set the command FIFO address width (depth 2^infifo_aw).
REQ-002 Parameter outfifo_aw, default 4, SHALL set the result FIFO address width (depth 2^outfifo_aw).
REQ-003 clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 host_din  in  9  command word: bit8=1 control, bit8=0 data byte.
REQ-006 host_we  in  1  push host_din into the command FIFO.
REQ-007 pace  in  1  bit-rate level signal; each rising edge is one SPI half-bit step.
REQ-008 miso  in  1  serial input, already registered by the caller.
REQ-009 result_re  in  1  pop the result FIFO.
REQ-010 sclk  out  1  SPI clock, idle low.
REQ-011 mosi  out  1  SPI data out, MSB first.
REQ-012 ctl_bits  out  6  latched control field (chip selects, direction) for the caller.
REQ-013 result_dout  out  8  result FIFO head, show-ahead, valid when result_count!=0.
REQ-014 cmd_full, cmd_empty  out  1 each  command FIFO flags.
REQ-015 result_count  out  outfifo_aw+1  result FIFO occupancy, 0..2^outfifo_aw.

Function
REQ-016 Both FIFOs SHALL be identical show-ahead FIFOs (generic sub-block "short FIFO"): dout equals the oldest entry whenever not empty, with no read latency.
REQ-017 FIFO write SHALL occur only when we=1 and not full; a write while full SHALL be dropped, including when re=1 in the same cycle.
REQ-018 FIFO read SHALL occur only when re=1 and not empty; a read while empty SHALL be ignored, and a simultaneous write still succeeds.
REQ-019 Simultaneous accepted read and write SHALL leave count unchanged; pointers SHALL wrap modulo depth; full means count==depth.
REQ-020 The engine SHALL detect pace rising edges (pace_step = pace & ~pace_d1); all bit timing SHALL advance only on pace_step.
REQ-021 States: IDLE, SHIFT. In IDLE with cmd_empty=0, the engine SHALL pop one word (single-cycle internal pull) in that cycle.
REQ-022 On a popped control word (bit8=1), ctl_bits SHALL take bits[5:0] on the next clock, and the engine SHALL stay in IDLE, with no SPI activity and no result.
REQ-023 On a popped data word (bit8=0), the engine SHALL load bits[7:0] into a shift register and enter SHIFT.
REQ-024 In SHIFT, for each of 8 bits, MSB first: on an odd pace_step, mosi = current bit and sclk=0; on the following pace_step, sclk=1 and miso is sampled into the LSB of the receive register.
REQ-025 After the 8th high phase, the next pace_step SHALL set sclk=0 and return to IDLE, and result_we SHALL pulse exactly one clock with the received byte, MSB = first sampled bit.
REQ-026 One data byte SHALL therefore occupy 17 pace steps from pop to result_we; sclk SHALL show exactly 8 high pulses.
REQ-027 A result written while the result FIFO is full SHALL be dropped; the engine SHALL never stall on the result FIFO.
REQ-028 Commands SHALL execute strictly in FIFO order; ctl_bits SHALL never change during SHIFT.
REQ-029 mosi SHALL hold its last value between bytes; sclk SHALL be 0 whenever in IDLE.

Reset
REQ-030 rst_n=0 at a clock edge SHALL empty both FIFOs, set the state to IDLE, sclk=0, mosi=0, ctl_bits=0, result_we=0, the shift counter to 0, and pace_d1=0.
REQ-031 Reset mid-byte SHALL abort the transfer with no result written; FIFO memory contents need not be cleared.

Verification
REQ-032 Write 0x105 with pace held low -> ctl_bits=0x05 within 2 clocks, cmd_empty=1, sclk stays 0, result_count=0.
REQ-033 Write 0x0A5 with pace toggling and miso tied 1 -> mosi pattern 1,0,1,0,0,1,0,1 at the sclk rising edges, 8 sclk pulses, result_count=1, result_dout=0xFF.
REQ-034 Write 0x03C with miso driven to loop back mosi -> result_dout=0x3C; a result_re pulse then gives result_count=0.
REQ-035 Write 33 words with pace=0 (infifo_aw=5) -> cmd_full=1 after 32 writes, the 33rd is dropped, and exactly 32 commands execute.
REQ-036 Send 17 data bytes without reading results -> result_count saturates at 16, the 17th result is dropped, and the first 16 read back in order.
REQ-037 Assert rst_n=0 during the 4th bit -> sclk=0, cmd_empty=1, result_count=0, ctl_bits=0 next cycle, and no result_we pulse.
